// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter for a single-ported synchronous-read memory.
// Define MEM_ARB_RR_EN for round-robin contention instead of D priority with a starvation guard.
module mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_adr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [3:0]        mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_d
);

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_IF   = 2'd1,
        R_D    = 2'd2
    } resp_t;

    resp_t r_resp_st;
    logic  w_if_wins_tie;

`ifdef MEM_ARB_RR_EN
    // 0 = D won the last contention, 1 = IF won it; the other port takes the next one.
    logic r_last_gnt;

    assign w_if_wins_tie = ~r_last_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt <= 1'b0;
        end else if (if_req && d_req) begin
            r_last_gnt <= if_gnt;
        end
    end
`else
    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;

    assign w_if_wins_tie = (r_starve_cnt == LP_STARVE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (if_req && !if_gnt) begin
            if (r_starve_cnt != LP_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end
`endif

    assign if_gnt   = if_req & (~d_req | w_if_wins_tie);
    assign d_gnt    = d_req & ~if_gnt;
    assign stall_if = if_req & ~if_gnt;
    assign stall_d  = d_req & ~d_gnt;

    always_comb begin
        mem_adr   = '0;
        mem_we    = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_adr = if_adr;
        end else if (d_gnt) begin
            mem_adr   = d_adr;
            mem_we    = d_we;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_st <= R_NONE;
        end else if (if_gnt) begin
            r_resp_st <= R_IF;
        end else if (d_gnt && (d_we == 4'b0000)) begin
            r_resp_st <= R_D;
        end else begin
            r_resp_st <= R_NONE;
        end
    end

    assign if_rvalid = (r_resp_st == R_IF);
    assign d_rvalid  = (r_resp_st == R_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (default build): vector table plus reset corner sequence.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_adr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic [3:0]    d_we;
    logic [AW-1:0] d_adr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_adr;
    logic [3:0]    mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if, stall_d;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_adr(if_adr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_d(stall_d)
    );

    // Write-first synchronous memory driven by the DUT, plus a reference copy updated from expectations.
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin : mem_model
        logic [DW-1:0] w;
        w = mem[mem_adr];
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
        end
        mem[mem_adr] = w;
        mem_rdata <= w;
    end

    typedef struct {
        logic          if_req;
        logic [AW-1:0] if_adr;
        logic          d_req;
        logic [3:0]    d_we;
        logic [AW-1:0] d_adr;
        logic [DW-1:0] d_wdata;
        logic          exp_if;
        logic          exp_d;
    } vec_t;

    typedef struct {
        int            port;   // 0 none, 1 IF, 2 D
        logic [DW-1:0] data;
    } resp_t;

    resp_t sb[$];
    vec_t  vecs[20];
    int    n_vec = 0;
    int    n_err = 0;

    function automatic vec_t mk(input logic ir, input logic [AW-1:0] ia, input logic dr,
                                input logic [3:0] we, input logic [AW-1:0] da,
                                input logic [DW-1:0] wd, input logic ei, input logic ed);
        vec_t v;
        v.if_req = ir; v.if_adr = ia; v.d_req = dr; v.d_we = we;
        v.d_adr = da; v.d_wdata = wd; v.exp_if = ei; v.exp_d = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_resp();
        resp_t e;
        e.port = 0;
        e.data = '0;
        if (sb.size() > 0) e = sb.pop_front();
        chk("if_rvalid", 32'(if_rvalid), 32'(e.port == 1));
        chk("d_rvalid",  32'(d_rvalid),  32'(e.port == 2));
        chk("if_rdata",  if_rdata, (e.port == 1) ? e.data : '0);
        chk("d_rdata",   d_rdata,  (e.port == 2) ? e.data : '0);
    endtask

    task automatic step(input vec_t v);
        resp_t         e;
        logic [DW-1:0] w;
        @(negedge clk);
        check_resp();
        if_req = v.if_req; if_adr = v.if_adr; d_req = v.d_req;
        d_we = v.d_we; d_adr = v.d_adr; d_wdata = v.d_wdata;
        #1;
        chk("if_gnt",   32'(if_gnt),   32'(v.exp_if));
        chk("d_gnt",    32'(d_gnt),    32'(v.exp_d));
        chk("stall_if", 32'(stall_if), 32'(v.if_req & ~v.exp_if));
        chk("stall_d",  32'(stall_d),  32'(v.d_req & ~v.exp_d));
        chk("mem_adr",  32'(mem_adr),  v.exp_if ? 32'(v.if_adr) : v.exp_d ? 32'(v.d_adr) : 32'h0);
        chk("mem_we",   32'(mem_we),   v.exp_d ? 32'(v.d_we) : 32'h0);
        chk("mem_wdata", mem_wdata,    v.exp_d ? v.d_wdata : '0);
        e.port = 0;
        e.data = '0;
        if (v.exp_if) begin
            e.port = 1; e.data = ref_mem[v.if_adr];
        end else if (v.exp_d && v.d_we == 4'b0000) begin
            e.port = 2; e.data = ref_mem[v.d_adr];
        end else if (v.exp_d) begin
            w = ref_mem[v.d_adr];
            for (int b = 0; b < 4; b++) begin
                if (v.d_we[b]) w[b*8 +: 8] = v.d_wdata[b*8 +: 8];
            end
            ref_mem[v.d_adr] = w;
        end
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i]     = (i * 32'h01010101) ^ 32'hA5000000;
            ref_mem[i] = (i * 32'h01010101) ^ 32'hA5000000;
        end
        mem[16]     = 32'h00000013;
        ref_mem[16] = 32'h00000013;
        mem_rdata   = '0;

        //            ifr  if_adr  dr  we       d_adr   wdata         eIF eD
        vecs[0]  = mk(1, 12'h010, 0, 4'b0000, 12'h000, 32'h0,        1, 0);
        vecs[1]  = mk(0, 12'h000, 1, 4'b0001, 12'h004, 32'h000000AB, 0, 1);
        vecs[2]  = mk(0, 12'h000, 1, 4'b0000, 12'h004, 32'h0,        0, 1);
        vecs[3]  = mk(0, 12'h000, 0, 4'b0000, 12'h000, 32'h0,        0, 0);
        vecs[4]  = mk(1, 12'h020, 1, 4'b0000, 12'h030, 32'h0,        0, 1);
        vecs[5]  = mk(1, 12'h020, 1, 4'b0000, 12'h031, 32'h0,        0, 1);
        vecs[6]  = mk(1, 12'h020, 1, 4'b0000, 12'h032, 32'h0,        0, 1);
        vecs[7]  = mk(1, 12'h020, 1, 4'b0000, 12'h033, 32'h0,        0, 1);
        vecs[8]  = mk(1, 12'h020, 1, 4'b0000, 12'h034, 32'h0,        1, 0);
        vecs[9]  = mk(1, 12'h021, 1, 4'b0000, 12'h034, 32'h0,        0, 1);
        vecs[10] = mk(1, 12'h021, 1, 4'b0000, 12'h035, 32'h0,        0, 1);
        vecs[11] = mk(1, 12'h021, 1, 4'b0000, 12'h036, 32'h0,        0, 1);
        vecs[12] = mk(0, 12'h000, 0, 4'b0000, 12'h000, 32'h0,        0, 0);
        vecs[13] = mk(1, 12'h011, 0, 4'b0000, 12'h000, 32'h0,        1, 0);
        vecs[14] = mk(0, 12'h000, 1, 4'b0000, 12'h012, 32'h0,        0, 1);
        vecs[15] = mk(1, 12'h040, 1, 4'b1111, 12'h040, 32'hDEADBEEF, 0, 1);
        vecs[16] = mk(1, 12'h040, 0, 4'b0000, 12'h000, 32'h0,        1, 0);
        vecs[17] = mk(0, 12'h000, 1, 4'b1100, 12'h040, 32'h12345678, 0, 1);
        vecs[18] = mk(0, 12'h000, 1, 4'b0000, 12'h040, 32'h0,        0, 1);
        vecs[19] = mk(0, 12'h000, 0, 4'b0000, 12'h000, 32'h0,        0, 0);

        reset = 1'b1;
        if_req = 0; if_adr = '0; d_req = 0; d_we = '0; d_adr = '0; d_wdata = '0;
        #1;
        chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
        chk("rst_d_rvalid",  32'(d_rvalid),  32'h0);
        chk("rst_if_rdata",  if_rdata, '0);
        chk("rst_d_rdata",   d_rdata,  '0);
        chk("rst_gnts",      32'({if_gnt, d_gnt, stall_if, stall_d}), 32'h0);
        chk("rst_mem_adr",   32'(mem_adr), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) step(vecs[i]);

        // Build up starvation (count 3), then reset between a D read grant and its response.
        step(mk(1, 12'h050, 1, 4'b0000, 12'h060, 32'h0, 0, 1));
        step(mk(1, 12'h050, 1, 4'b0000, 12'h061, 32'h0, 0, 1));
        step(mk(1, 12'h050, 1, 4'b0000, 12'h062, 32'h0, 0, 1));
        #2;
        reset = 1'b1;
        if_req = 0; d_req = 0; d_we = '0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        sb.delete();
        chk("post_rst_d_rvalid", 32'(d_rvalid), 32'h0);
        // With the count cleared, IF only wins on the fifth contended cycle.
        step(mk(1, 12'h070, 1, 4'b0000, 12'h080, 32'h0, 0, 1));
        step(mk(1, 12'h070, 1, 4'b0000, 12'h081, 32'h0, 0, 1));
        step(mk(1, 12'h070, 1, 4'b0000, 12'h082, 32'h0, 0, 1));
        step(mk(1, 12'h070, 1, 4'b0000, 12'h083, 32'h0, 0, 1));
        step(mk(1, 12'h070, 1, 4'b0000, 12'h084, 32'h0, 1, 0));
        step(mk(0, 12'h000, 0, 4'b0000, 12'h000, 32'h0, 0, 0));

        // Second mid-read reset, then the first IF request must be granted at once.
        step(mk(0, 12'h000, 1, 4'b0000, 12'h090, 32'h0, 0, 1));
        #2;
        reset = 1'b1;
        d_req = 0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        sb.delete();
        chk("post_rst2_d_rvalid", 32'(d_rvalid), 32'h0);
        step(mk(1, 12'h010, 0, 4'b0000, 12'h000, 32'h0, 1, 0));
        step(mk(0, 12'h000, 0, 4'b0000, 12'h000, 32'h0, 0, 0));
        @(negedge clk);
        check_resp();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
